text_console: RTL and testbench



---
 rtl/text_console_if.sv | 19 +
 rtl/text_console.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_text_console.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_console_if.sv
// Character stream handshake between a byte source and text_console.
// The master drives data/valid; the console answers with ready.
interface text_console_if;
    logic [7:0] ch_data;
    logic       ch_valid;
    logic       ch_ready;

    modport master (
        output ch_data,
        output ch_valid,
        input  ch_ready
    );

    modport slave (
        input  ch_data,
        input  ch_valid,
        output ch_ready
    );
endinterface

// File: rtl/text_console.sv
// Text-mode renderer: COLS x ROWS character buffer with circular scroll,
// control-code decode, blinking cursor and a 3-cycle pixel pipeline.
module text_console #(
    parameter int         SCREEN_W   = 96,
    parameter int         SCREEN_H   = 64,
    parameter int         CHAR_H     = 16,
    parameter int         XW         = 8,
    parameter int         YW         = 6,
    parameter logic [7:0] FG_COLOR   = 8'hFF,
    parameter logic [7:0] BG_COLOR   = 8'h00,
    parameter int         CURSOR_EN  = 1,
    parameter int         BLINK_BITS = 23,
    localparam int        HW         = $clog2(CHAR_H)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XW-1:0]   x,
    input  logic [YW-1:0]   y,
    output logic [7:0]      color,
    output logic [8+HW-1:0] font_addr,
    input  logic [7:0]      font_data,
    text_console_if.slave   bus,
    output logic            busy
);
    localparam int COLS  = SCREEN_W / 8;
    localparam int ROWS  = SCREEN_H / CHAR_H;
    localparam int CELLS = COLS * ROWS;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW    = $clog2(CELLS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_CLRROW
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [RW-1:0]   r_top;
    logic [RW-1:0]   r_clr_row;
    logic [AW-1:0]   r_cnt;
    logic [BLINK_BITS-1:0] r_blink;
    logic [7:0]      r_mem [0:CELLS-1];

    logic            w_idle;
    logic            w_acc;
    logic            w_is_cr;
    logic            w_is_bs;
    logic            w_is_lf;
    logic            w_is_ff;
    logic            w_is_pr;
    logic            w_wrap;
    logic            w_nl;
    logic            w_scroll;
    logic [RW-1:0]   w_top_inc;
    logic            w_ready;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [7:0]      w_wdata;

    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [CW-1:0]   w_px_col;
    logic [RW-1:0]   w_px_lrow;
    logic            w_oor;
    logic            w_cur_hit;
    logic [AW-1:0]   w_rd_addr;
    logic [7:0]      r_char;
    logic [HW-1:0]   r_grow1;
    logic [2:0]      r_bit1;
    logic [2:0]      r_bit2;
    logic            r_oor1;
    logic            r_oor2;
    logic            r_cur1;
    logic            r_cur2;
    logic            w_pix;

    function automatic logic [RW-1:0] f_phys(
        input logic [RW-1:0] l,
        input logic [RW-1:0] t
    );
        logic [RW:0] s;
        s = {1'b0, l} + {1'b0, t};
        if (s >= (RW+1)'(ROWS))
            s = s - (RW+1)'(ROWS);
        return s[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] f_addr(
        input logic [RW-1:0] p,
        input logic [CW-1:0] c
    );
        return AW'(p) * AW'(COLS) + AW'(c);
    endfunction

    assign w_idle = (r_state == S_IDLE);
    assign w_acc  = bus.ch_valid & w_idle;

    // Classify the byte being accepted this cycle.
    always_comb begin
        w_is_cr = 1'b0;
        w_is_bs = 1'b0;
        w_is_lf = 1'b0;
        w_is_ff = 1'b0;
        w_is_pr = 1'b0;
        if (w_acc) begin
            unique case (bus.ch_data)
                8'h0D:   w_is_cr = 1'b1;
                8'h08:   w_is_bs = 1'b1;
                8'h0A:   w_is_lf = 1'b1;
                8'h0C:   w_is_ff = 1'b1;
                default: w_is_pr = 1'b1;
            endcase
        end
    end

    assign w_wrap    = w_is_pr && (r_col == CW'(COLS - 1));
    assign w_nl      = w_is_lf || w_wrap;
    assign w_scroll  = w_nl && (r_row == RW'(ROWS - 1));
    assign w_top_inc = (r_top == RW'(ROWS - 1)) ? '0 : r_top + RW'(1);

    // State register; reset always restarts a full clear.
    always_ff @(posedge clk) begin
        if (!resetn)
            r_state <= S_CLEAR;
        else
            r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_is_ff)
                    w_next = S_CLEAR;
                else if (w_scroll)
                    w_next = S_CLRROW;
            end
            S_CLEAR: begin
                if (r_cnt == AW'(CELLS - 1))
                    w_next = S_IDLE;
            end
            S_CLRROW: begin
                if (r_cnt == AW'(COLS - 1))
                    w_next = S_IDLE;
            end
            default: w_next = S_CLEAR;
        endcase
    end

    // Handshake, busy flag and buffer write port.
    always_comb begin
        w_ready = 1'b0;
        busy    = 1'b0;
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = 8'h20;
        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                w_we    = w_is_pr;
                w_waddr = f_addr(f_phys(r_row, r_top), r_col);
                w_wdata = bus.ch_data;
            end
            S_CLEAR: begin
                busy    = 1'b1;
                w_we    = 1'b1;
                w_waddr = r_cnt;
            end
            S_CLRROW: begin
                busy    = 1'b1;
                w_we    = 1'b1;
                w_waddr = f_addr(r_clr_row, CW'(r_cnt));
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign bus.ch_ready = w_ready;

    // Cursor, scroll offset and clear counter updates.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_col     <= '0;
            r_row     <= '0;
            r_top     <= '0;
            r_clr_row <= '0;
            r_cnt     <= '0;
        end else if (w_idle) begin
            r_cnt <= '0;
            if (w_is_ff) begin
                r_col <= '0;
                r_row <= '0;
                r_top <= '0;
            end else if (w_is_cr) begin
                r_col <= '0;
            end else if (w_is_bs) begin
                if (r_col != '0)
                    r_col <= r_col - CW'(1);
            end else if (w_is_pr && !w_wrap) begin
                r_col <= r_col + CW'(1);
            end
            if (w_wrap)
                r_col <= '0;
            if (w_nl) begin
                if (w_scroll) begin
                    r_top     <= w_top_inc;
                    r_clr_row <= r_top;
                end else begin
                    r_row <= r_row + RW'(1);
                end
            end
        end else begin
            r_cnt <= r_cnt + AW'(1);
        end
    end

    // Free-running blink counter; its MSB is the blink phase.
    always_ff @(posedge clk) begin
        if (!resetn)
            r_blink <= '0;
        else
            r_blink <= r_blink + BLINK_BITS'(1);
    end

    // Character buffer write port.
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    // S0: capture the pixel request.
    always_ff @(posedge clk) begin
        r_x <= x;
        r_y <= y;
    end

    assign w_px_col  = CW'(r_x[XW-1:3]);
    assign w_px_lrow = RW'(r_y[YW-1:HW]);
    assign w_oor     = ({1'b0, r_x} >= (XW+1)'(COLS * 8)) ||
                       ({1'b0, r_y} >= (YW+1)'(ROWS * CHAR_H));
    assign w_rd_addr = w_oor ? '0 :
                       f_addr(f_phys(w_px_lrow, r_top), w_px_col);
    assign w_cur_hit = (CURSOR_EN != 0) && r_blink[BLINK_BITS-1] &&
                       w_idle && !w_oor &&
                       (w_px_col == r_col) && (w_px_lrow == r_row);

    // S1: read-first buffer lookup plus aligned side information.
    always_ff @(posedge clk) begin
        r_char  <= r_mem[w_rd_addr];
        r_grow1 <= r_y[HW-1:0];
        r_bit1  <= r_x[2:0];
        r_oor1  <= w_oor;
        r_cur1  <= w_cur_hit;
    end

    assign font_addr = {r_char, r_grow1};

    // S2: hold side information while font_rom answers.
    always_ff @(posedge clk) begin
        r_bit2 <= r_bit1;
        r_oor2 <= r_oor1;
        r_cur2 <= r_cur1;
    end

    assign w_pix = font_data[3'd7 - r_bit2];

    // S3: final colour, with cursor inversion.
    always_ff @(posedge clk) begin
        if (!resetn)
            color <= 8'h00;
        else if (r_oor2)
            color <= BG_COLOR;
        else
            color <= (w_pix ^ r_cur2) ? FG_COLOR : BG_COLOR;
    end
endmodule

// File: tb/tb_text_console.sv
// Scoreboard bench for text_console: directed byte stream, model screen,
// pixel expectations queued at request time and checked by a monitor.
module tb_text_console;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  px = '0;
    logic [5:0]  py = '0;
    logic [7:0]  color;
    logic [11:0] font_addr;
    logic [7:0]  font_data = '0;
    logic        busy;

    text_console_if cbus();

    text_console dut (
        .clk       (clk),
        .resetn    (resetn),
        .x         (px),
        .y         (py),
        .color     (color),
        .font_addr (font_addr),
        .font_data (font_data),
        .bus       (cbus),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_wait;
    int last_at;

    logic [7:0] m_scr [4][12];
    int  m_col;
    int  m_row;
    int  m_top;
    bit  m_blink;

    logic [7:0] exp_q [$];
    logic       req_v = 1'b0;
    logic [3:0] pv = '0;

    function automatic logic [7:0] font_fn(input logic [7:0] c,
                                           input logic [3:0] r);
        if (c == 8'h20)
            return 8'h00;
        return c ^ ({4'h0, r} * 8'd17) ^ 8'h5A;
    endfunction

    // Registered font ROM
    always @(posedge clk)
        font_data <= font_fn(font_addr[11:4], font_addr[3:0]);

    always @(posedge clk) cyc++;

    always @(posedge clk) pv <= {pv[2:0], req_v};

    // Pixel monitor: one result per request, 3 cycles later
    always @(negedge clk) begin
        logic [7:0] e;
        if (pv[3]) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pixel_underflow got %h exp none", color);
            end else begin
                e = exp_q.pop_front();
                if (color !== e) begin
                    n_fail++;
                    $display("FAIL pixel got %h exp %h", color, e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    task automatic m_clear();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 12; c++)
                m_scr[r][c] = 8'h20;
    endtask

    task automatic m_nl();
        if (m_row < 3) begin
            m_row++;
        end else begin
            for (int r = 0; r < 3; r++)
                m_scr[r] = m_scr[r+1];
            for (int c = 0; c < 12; c++)
                m_scr[3][c] = 8'h20;
            m_top = (m_top + 1) % 4;
        end
    endtask

    task automatic m_apply(input logic [7:0] b);
        case (b)
            8'h0D: m_col = 0;
            8'h08: if (m_col > 0) m_col--;
            8'h0A: m_nl();
            8'h0C: begin
                m_clear();
                m_col = 0;
                m_row = 0;
                m_top = 0;
            end
            default: begin
                m_scr[m_row][m_col] = b;
                if (m_col == 11) begin
                    m_col = 0;
                    m_nl();
                end else begin
                    m_col++;
                end
            end
        endcase
    endtask

    function automatic logic [7:0] exp_pix(input int xx, input int yy);
        logic [7:0] g;
        logic p;
        if (xx >= 96 || yy >= 64)
            return 8'h00;
        g = font_fn(m_scr[yy/16][xx/8], 4'(yy % 16));
        p = g[7 - (xx % 8)];
        if (m_blink && (xx / 8 == m_col) && (yy / 16 == m_row))
            p = ~p;
        return p ? 8'hFF : 8'h00;
    endfunction

    // Called at a negedge; returns at the negedge after acceptance
    task automatic send(input logic [7:0] b);
        cbus.ch_valid = 1'b1;
        cbus.ch_data = b;
        last_wait = 0;
        while (cbus.ch_ready !== 1'b1 && last_wait < 200) begin
            @(negedge clk);
            last_wait++;
        end
        if (last_wait >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout byte %h", b);
            cbus.ch_valid = 1'b0;
            return;
        end
        last_at = cyc;
        @(negedge clk);
        cbus.ch_valid = 1'b0;
        m_apply(b);
    endtask

    task automatic send_n(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++)
            send(b);
    endtask

    task automatic probe(input int xx, input int yy);
        px = 8'(xx);
        py = 6'(yy);
        req_v = 1'b1;
        exp_q.push_back(exp_pix(xx, yy));
        @(negedge clk);
    endtask

    task automatic probe_end();
        req_v = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic sweep(input int x0, input int x1,
                         input int y0, input int y1);
        for (int yy = y0; yy < y1; yy++)
            for (int xx = x0; xx < x1; xx++)
                probe(xx, yy);
        probe_end();
    endtask

    task automatic check_cursor(input string nm);
        check({nm, "_col"}, 32'(dut.r_col), m_col);
        check({nm, "_row"}, 32'(dut.r_row), m_row);
        check({nm, "_top"}, 32'(dut.r_top), m_top);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int a0;
        cbus.ch_valid = 1'b0;
        cbus.ch_data = 8'h00;
        m_blink = 1'b0;
        m_clear();
        m_col = 0;
        m_row = 0;
        m_top = 0;

        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_color", color, 8'h00);
        check("rst_ready", cbus.ch_ready, 0);
        check("rst_busy", busy, 1);
        resetn = 1'b1;
        n = 0;
        while (cbus.ch_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("clear_len", n, 48);
        check("idle_busy", busy, 0);
        check_cursor("rst");
        sweep(0, 104, 0, 64);

        send(8'h48);
        a0 = last_at;
        send(8'h49);
        check("hi_wait", last_wait, 0);
        check("hi_consec", last_at - a0, 1);
        check_cursor("hi");
        sweep(0, 16, 0, 16);

        send(8'h0D);
        send_n(8'h41, 12);
        send(8'h42);
        check_cursor("ab");
        sweep(0, 96, 0, 32);

        send(8'h0D);
        for (int i = 0; i < 12; i++)
            send(8'(8'h61 + i));
        for (int i = 0; i < 12; i++)
            send(8'(8'h6D + i));
        for (int i = 0; i < 11; i++)
            send(8'(8'h30 + i));
        check_cursor("fill");
        send(8'h0A);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("scroll_busy", n, 12);
        check_cursor("scroll");
        sweep(0, 96, 0, 64);

        send(8'h0D);
        send(8'h51);
        check_cursor("wrap_wr");
        sweep(0, 16, 48, 64);

        send(8'h0D);
        send(8'h08);
        check_cursor("bs_col0");
        send(8'h78);
        send(8'h79);
        send(8'h08);
        check_cursor("bs_col2");
        sweep(0, 24, 48, 64);

        send(8'h0C);
        check_cursor("ff");
        send(8'h5A);
        check("held_wait", last_wait, 48);
        check_cursor("held");
        sweep(0, 96, 0, 64);

        send(8'h0C);
        n = 0;
        while (cbus.ch_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("ff2_len", n, 48);
        force dut.r_blink = 23'h400000;
        m_blink = 1'b1;
        for (int yy = 0; yy < 16; yy++)
            for (int xx = 0; xx < 9; xx++)
                probe(xx, yy);
        probe(100, 0);
        probe_end();
        release dut.r_blink;
        m_blink = 1'b0;

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
